// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
package id_ex_stage_pkg;

  localparam int unsigned XLenDefault = 32;
  localparam int unsigned CntWDefault = 16;
  localparam int unsigned RegIdxW     = 5;
  localparam int unsigned AluOpW      = 4;

  // ALU operation encodings carried on the ALUOp control field.
  typedef enum logic [AluOpW-1:0] {
    AluAdd  = 4'h0,
    AluSub  = 4'h1,
    AluAnd  = 4'h2,
    AluOr   = 4'h3,
    AluXor  = 4'h4,
    AluSll  = 4'h5,
    AluSrl  = 4'h6,
    AluSra  = 4'h7,
    AluSlt  = 4'h8,
    AluSltu = 4'h9,
    AluLui  = 4'ha,
    AluPass = 4'hb
  } alu_op_e;

  // Decode control bundle travelling down the pipe with the instruction.
  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [AluOpW-1:0] alu_op;
  } ctl_t;

  localparam ctl_t CtlBubble = '0;

  // Controls of an empty slot must never cause side effects downstream.
  function automatic ctl_t gate_ctl(input ctl_t ctl, input logic valid);
    return valid ? ctl : CtlBubble;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and front-end stall decision (purely combinational).
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic               rst_ni,
  input  logic               ex_valid_i,
  input  logic               ex_mem_read_i,
  input  logic [RegIdxW-1:0] ex_rd_i,
  input  logic               id_valid_i,
  input  logic [RegIdxW-1:0] id_rs1_i,
  input  logic [RegIdxW-1:0] id_rs2_i,
  input  logic               id_use_rs1_i,
  input  logic               id_use_rs2_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               lu_o,
  output logic               stall_o
);

  logic rs1_hit, rs2_hit;

  // A load in EX whose result the decode slot needs cannot be forwarded in time.
  always_comb begin
    rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    lu_o    = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && id_valid_i
              && (rs1_hit || rs2_hit);
    // Flush redirects the front end, so freezing it would be wrong; reset forces 0.
    stall_o = rst_ni && !flush_i && (hold_i || lu_o);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = XLenDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid_in,
  input  logic [RegIdxW-1:0] id_Rs1_in,
  input  logic [RegIdxW-1:0] id_Rs2_in,
  input  logic [RegIdxW-1:0] id_Rd_in,
  input  logic               id_use_Rs1_in,
  input  logic               id_use_Rs2_in,
  input  logic               id_Ctl_RegWrite_in,
  input  logic               id_Ctl_MemRead_in,
  input  logic               id_Ctl_MemWrite_in,
  input  logic               id_Ctl_ALUSrc_in,
  input  logic [AluOpW-1:0]  id_Ctl_ALUOp_in,
  input  logic [XLEN-1:0]    id_PC_in,
  input  logic [XLEN-1:0]    id_Imm_in,
  input  logic [XLEN-1:0]    id_Rs1_data_in,
  input  logic [XLEN-1:0]    id_Rs2_data_in,
  input  logic               flush_in,
  input  logic               hold_in,
  output logic               ex_valid_out,
  output logic [RegIdxW-1:0] ex_Rs1_out,
  output logic [RegIdxW-1:0] ex_Rs2_out,
  output logic [RegIdxW-1:0] ex_Rd_out,
  output logic               ex_Ctl_RegWrite_out,
  output logic               ex_Ctl_MemRead_out,
  output logic               ex_Ctl_MemWrite_out,
  output logic               ex_Ctl_ALUSrc_out,
  output logic [AluOpW-1:0]  ex_Ctl_ALUOp_out,
  output logic [XLEN-1:0]    ex_PC_out,
  output logic [XLEN-1:0]    ex_Imm_out,
  output logic [XLEN-1:0]    ex_Rs1_data_out,
  output logic [XLEN-1:0]    ex_Rs2_data_out,
  output logic               stall_out,
  output logic [CNT_W-1:0]   stall_cnt_out
);

  logic               ex_valid_q,    ex_valid_d;
  logic [RegIdxW-1:0] ex_rs1_q,      ex_rs1_d;
  logic [RegIdxW-1:0] ex_rs2_q,      ex_rs2_d;
  logic [RegIdxW-1:0] ex_rd_q,       ex_rd_d;
  ctl_t               ex_ctl_q,      ex_ctl_d;
  logic [XLEN-1:0]    ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]    ex_imm_q,      ex_imm_d;
  logic [XLEN-1:0]    ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]    ex_rs2_data_q, ex_rs2_data_d;
  logic [CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;

  ctl_t id_ctl;
  logic lu;
  logic bubble;

  assign id_ctl = '{
    reg_write: id_Ctl_RegWrite_in,
    mem_read:  id_Ctl_MemRead_in,
    mem_write: id_Ctl_MemWrite_in,
    alu_src:   id_Ctl_ALUSrc_in,
    alu_op:    id_Ctl_ALUOp_in
  };

  id_ex_stage_hazard_detect u_hazard_detect (
    .rst_ni        (rst_n),
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctl_q.mem_read),
    .ex_rd_i       (ex_rd_q),
    .id_valid_i    (id_valid_in),
    .id_rs1_i      (id_Rs1_in),
    .id_rs2_i      (id_Rs2_in),
    .id_use_rs1_i  (id_use_Rs1_in),
    .id_use_rs2_i  (id_use_Rs2_in),
    .flush_i       (flush_in),
    .hold_i        (hold_in),
    .lu_o          (lu),
    .stall_o       (stall_out)
  );

  // Next EX slot: flush > hold > load-use bubble > normal capture.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_ctl_d      = ex_ctl_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    stall_cnt_d   = stall_cnt_q;

    bubble = flush_in || (!hold_in && lu);

    if (bubble) begin
      ex_valid_d    = 1'b0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rd_d       = '0;
      ex_ctl_d      = CtlBubble;
      ex_pc_d       = '0;
      ex_imm_d      = '0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
    end else if (!hold_in) begin
      ex_valid_d    = id_valid_in;
      ex_rs1_d      = id_Rs1_in;
      ex_rs2_d      = id_Rs2_in;
      ex_rd_d       = id_Rd_in;
      ex_ctl_d      = gate_ctl(id_ctl, id_valid_in);
      ex_pc_d       = id_PC_in;
      ex_imm_d      = id_Imm_in;
      ex_rs1_data_d = id_Rs1_data_in;
      ex_rs2_data_d = id_Rs2_data_in;
    end

    // Only bubbles that actually get inserted are counted; saturate instead of wrapping.
    if (!flush_in && !hold_in && lu && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // EX pipeline register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_ctl_q      <= CtlBubble;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctl_q      <= ex_ctl_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ex_valid_out        = ex_valid_q;
  assign ex_Rs1_out          = ex_rs1_q;
  assign ex_Rs2_out          = ex_rs2_q;
  assign ex_Rd_out           = ex_rd_q;
  assign ex_Ctl_RegWrite_out = ex_ctl_q.reg_write;
  assign ex_Ctl_MemRead_out  = ex_ctl_q.mem_read;
  assign ex_Ctl_MemWrite_out = ex_ctl_q.mem_write;
  assign ex_Ctl_ALUSrc_out   = ex_ctl_q.alu_src;
  assign ex_Ctl_ALUOp_out    = ex_ctl_q.alu_op;
  assign ex_PC_out           = ex_pc_q;
  assign ex_Imm_out          = ex_imm_q;
  assign ex_Rs1_data_out     = ex_rs1_data_q;
  assign ex_Rs2_data_out     = ex_rs2_data_q;
  assign stall_cnt_out       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against an instruction-slot reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN   = 32;
  localparam int CNT_W  = 4;
  localparam int CntMax = (1 << CNT_W) - 1;

  typedef logic [127:0] word_t;

  // Reference view of the instruction sitting in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, as;
    logic [3:0]  op;
    logic [31:0] pc, imm, d1, d2;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid_in, id_use_Rs1_in, id_use_Rs2_in;
  logic [4:0] id_Rs1_in, id_Rs2_in, id_Rd_in;
  logic id_Ctl_RegWrite_in, id_Ctl_MemRead_in, id_Ctl_MemWrite_in, id_Ctl_ALUSrc_in;
  logic [3:0] id_Ctl_ALUOp_in;
  logic [XLEN-1:0] id_PC_in, id_Imm_in, id_Rs1_data_in, id_Rs2_data_in;
  logic flush_in, hold_in;
  logic ex_valid_out;
  logic [4:0] ex_Rs1_out, ex_Rs2_out, ex_Rd_out;
  logic ex_Ctl_RegWrite_out, ex_Ctl_MemRead_out, ex_Ctl_MemWrite_out, ex_Ctl_ALUSrc_out;
  logic [3:0] ex_Ctl_ALUOp_out;
  logic [XLEN-1:0] ex_PC_out, ex_Imm_out, ex_Rs1_data_out, ex_Rs2_data_out;
  logic stall_out;
  logic [CNT_W-1:0] stall_cnt_out;

  int    n_tests = 0;
  int    n_fail  = 0;
  slot_t ex_m;
  int    cnt_m;
  logic  stall_seen;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .id_valid_in         (id_valid_in),
    .id_Rs1_in           (id_Rs1_in),
    .id_Rs2_in           (id_Rs2_in),
    .id_Rd_in            (id_Rd_in),
    .id_use_Rs1_in       (id_use_Rs1_in),
    .id_use_Rs2_in       (id_use_Rs2_in),
    .id_Ctl_RegWrite_in  (id_Ctl_RegWrite_in),
    .id_Ctl_MemRead_in   (id_Ctl_MemRead_in),
    .id_Ctl_MemWrite_in  (id_Ctl_MemWrite_in),
    .id_Ctl_ALUSrc_in    (id_Ctl_ALUSrc_in),
    .id_Ctl_ALUOp_in     (id_Ctl_ALUOp_in),
    .id_PC_in            (id_PC_in),
    .id_Imm_in           (id_Imm_in),
    .id_Rs1_data_in      (id_Rs1_data_in),
    .id_Rs2_data_in      (id_Rs2_data_in),
    .flush_in            (flush_in),
    .hold_in             (hold_in),
    .ex_valid_out        (ex_valid_out),
    .ex_Rs1_out          (ex_Rs1_out),
    .ex_Rs2_out          (ex_Rs2_out),
    .ex_Rd_out           (ex_Rd_out),
    .ex_Ctl_RegWrite_out (ex_Ctl_RegWrite_out),
    .ex_Ctl_MemRead_out  (ex_Ctl_MemRead_out),
    .ex_Ctl_MemWrite_out (ex_Ctl_MemWrite_out),
    .ex_Ctl_ALUSrc_out   (ex_Ctl_ALUSrc_out),
    .ex_Ctl_ALUOp_out    (ex_Ctl_ALUOp_out),
    .ex_PC_out           (ex_PC_out),
    .ex_Imm_out          (ex_Imm_out),
    .ex_Rs1_data_out     (ex_Rs1_data_out),
    .ex_Rs2_data_out     (ex_Rs2_data_out),
    .stall_out           (stall_out),
    .stall_cnt_out       (stall_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output against the model's EX slot and counter.
  task automatic check_ex(input string tag);
    check({tag, ":valid"}, word_t'(ex_valid_out), word_t'(ex_m.v));
    check({tag, ":ctl"},
          word_t'({ex_Ctl_RegWrite_out, ex_Ctl_MemRead_out, ex_Ctl_MemWrite_out,
                   ex_Ctl_ALUSrc_out, ex_Ctl_ALUOp_out}),
          word_t'({ex_m.rw, ex_m.mr, ex_m.mw, ex_m.as, ex_m.op}));
    check({tag, ":idx"}, word_t'({ex_Rs1_out, ex_Rs2_out, ex_Rd_out}),
          word_t'({ex_m.rs1, ex_m.rs2, ex_m.rd}));
    check({tag, ":data"}, {ex_PC_out, ex_Imm_out, ex_Rs1_data_out, ex_Rs2_data_out},
          {ex_m.pc, ex_m.imm, ex_m.d1, ex_m.d2});
    check({tag, ":cnt"}, word_t'(stall_cnt_out), word_t'(cnt_m));
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic mw, input logic as,
                         input logic [3:0] op);
    id_valid_in = v;   id_Rs1_in = rs1; id_Rs2_in = rs2; id_Rd_in = rd;
    id_use_Rs1_in = u1; id_use_Rs2_in = u2;
    id_Ctl_RegWrite_in = rw; id_Ctl_MemRead_in = mr;
    id_Ctl_MemWrite_in = mw; id_Ctl_ALUSrc_in = as; id_Ctl_ALUOp_in = op;
    id_PC_in = $urandom; id_Imm_in = $urandom;
    id_Rs1_data_in = $urandom; id_Rs2_data_in = $urandom;
  endtask

  // One clock: check the combinational stall, clock, advance the model, check EX.
  task automatic step(input string tag);
    logic hit, lu, exp_stall;
    #1;
    hit = (id_use_Rs1_in && id_Rs1_in == ex_m.rd) || (id_use_Rs2_in && id_Rs2_in == ex_m.rd);
    lu = ex_m.v && ex_m.mr && (ex_m.rd != 5'd0) && id_valid_in && hit;
    exp_stall = !flush_in && (hold_in || lu);
    stall_seen = stall_out;
    check({tag, ":stall"}, word_t'(stall_out), word_t'(exp_stall));
    @(posedge clk);
    if (flush_in) begin
      ex_m = '0;
    end else if (hold_in) begin
      ex_m = ex_m;
    end else if (lu) begin
      ex_m = '0;
      if (cnt_m < CntMax) cnt_m++;
    end else begin
      ex_m = '0;
      ex_m.v = id_valid_in;
      ex_m.rs1 = id_Rs1_in; ex_m.rs2 = id_Rs2_in; ex_m.rd = id_Rd_in;
      if (id_valid_in) begin
        ex_m.rw = id_Ctl_RegWrite_in; ex_m.mr = id_Ctl_MemRead_in;
        ex_m.mw = id_Ctl_MemWrite_in; ex_m.as = id_Ctl_ALUSrc_in; ex_m.op = id_Ctl_ALUOp_in;
      end
      ex_m.pc = id_PC_in; ex_m.imm = id_Imm_in;
      ex_m.d1 = id_Rs1_data_in; ex_m.d2 = id_Rs2_data_in;
    end
    #1;
    check_ex(tag);
  endtask

  // Mid-cycle asynchronous reset with hold asserted; everything must clear at once.
  task automatic do_async_reset(input string tag);
    hold_in = 1'b1;
    flush_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    ex_m = '0;
    cnt_m = 0;
    check({tag, ":stall"}, word_t'(stall_out), word_t'(0));
    check_ex(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_in = 1'b0;
  endtask

  initial begin
    ex_m = '0;
    cnt_m = 0;
    flush_in = 1'b0;
    hold_in = 1'b0;
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Power-up reset, asserted asynchronously before the first edge.
    #1;
    rst_n = 1'b0;
    hold_in = 1'b1;
    #2;
    check("por:stall", word_t'(stall_out), word_t'(0));
    check_ex("por");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_in = 1'b0;

    // lw x5 then add x6,x5,x7: one bubble, add enters the cycle after.
    set_dec(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("lw_x5");
    set_dec(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AluAdd);
    step("lu_stall");
    check("lu_stall:stall_hi", word_t'(stall_seen), word_t'(1));
    check("lu_stall:bubble", word_t'(ex_valid_out), word_t'(0));
    check("lu_stall:cnt1", word_t'(stall_cnt_out), word_t'(1));
    step("add_enters");
    check("add_enters:stall_lo", word_t'(stall_seen), word_t'(0));
    check("add_enters:rd6", word_t'({ex_valid_out, ex_Rd_out}), word_t'({1'b1, 5'd6}));

    // Back-to-back dependent loads each stall once.
    set_dec(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("b2b_lw1");
    set_dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("b2b_lw2_stall");
    step("b2b_lw2_enter");
    set_dec(1'b1, 5'd3, 5'd6, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AluSub);
    step("b2b_add_stall");
    step("b2b_add_enter");
    check("b2b:cnt3", word_t'(stall_cnt_out), word_t'(3));

    // lw x0 never stalls; use flag low suppresses a match.
    set_dec(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("lw_x0");
    set_dec(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AluOr);
    step("x0_nostall");
    check("x0_nostall:stall_lo", word_t'(stall_seen), word_t'(0));
    set_dec(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("lw_x5b");
    set_dec(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, AluLui);
    step("nouse_nostall");
    check("nouse_nostall:stall_lo", word_t'(stall_seen), word_t'(0));

    // Load-use and flush in the same cycle: flush wins, no count.
    set_dec(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
    step("lw_x5c");
    set_dec(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AluAdd);
    flush_in = 1'b1;
    step("lu_flush");
    check("lu_flush:stall_lo", word_t'(stall_seen), word_t'(0));
    check("lu_flush:cnt3", word_t'(stall_cnt_out), word_t'(3));
    flush_in = 1'b0;

    // Hold for three cycles with a valid EX slot, then release.
    set_dec(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AluXor);
    step("pre_hold");
    hold_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_dec(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, AluSra);
      step("hold");
      check("hold:stall_hi", word_t'(stall_seen), word_t'(1));
      check("hold:rd10", word_t'(ex_Rd_out), word_t'(10));
    end
    hold_in = 1'b0;
    step("hold_release");
    check("hold_release:rd13", word_t'(ex_Rd_out), word_t'(13));

    // Reset in the middle of a hold discards the held instruction.
    do_async_reset("rst_mid_hold");
    step("after_rst");

    // Seventeen load-use events saturate the 4-bit counter at 15.
    for (int i = 0; i < 17; i++) begin
      set_dec(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AluAdd);
      step("sat_lw");
      set_dec(1'b1, 5'd2, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, AluAdd);
      step("sat_stall");
      step("sat_enter");
    end
    check("sat:cnt15", word_t'(stall_cnt_out), word_t'(CntMax));

    // Randomized traffic; a stalled decode slot normally keeps its instruction.
    do_async_reset("rand_rst");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_async_reset("rand_rst");
      end else begin
        if (!stall_seen || $urandom_range(0, 3) == 0) begin
          set_dec($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 1) == 0, 1'($urandom), 1'($urandom), 4'($urandom));
        end
        flush_in = ($urandom_range(0, 9) == 0);
        hold_in  = ($urandom_range(0, 6) == 0);
        step("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk input 1 single clock; all flops rising-edge.
REQ-004 rst_n input 1 reset, asynchronous, active-low.
REQ-005 id_valid_in input 1 decode slot holds a real instruction.
REQ-006 id_Rs1_in, id_Rs2_in, id_Rd_in input 5 each: decode register indices.
REQ-007 id_use_Rs1_in, id_use_Rs2_in input 1 each: instruction actually reads Rs1/Rs2.
REQ-008 id_Ctl_RegWrite_in, id_Ctl_MemRead_in, id_Ctl_MemWrite_in, id_Ctl_ALUSrc_in input 1 each: decode controls.
REQ-009 id_Ctl_ALUOp_in input 4 ALU operation code.
REQ-010 id_PC_in, id_Imm_in, id_Rs1_data_in, id_Rs2_data_in input XLEN each.
REQ-011 flush_in input 1 taken branch/jump resolved in EX; kill EX and decode slot.
REQ-012 hold_in input 1 downstream (memory) not ready; freeze whole front end.
REQ-013 ex_valid_out output 1 EX slot valid.
REQ-014 ex_Rs1_out, ex_Rs2_out, ex_Rd_out output 5 each: registered indices, fed to forwarding comparison.
REQ-015 ex_Ctl_* outputs mirror REQ-008/009 widths, registered.
REQ-016 ex_PC_out, ex_Imm_out, ex_Rs1_data_out, ex_Rs2_data_out output XLEN each, registered.
REQ-017 stall_out output 1 freeze PC and IF/ID register this cycle.
REQ-018 stall_cnt_out output CNT_W saturating count of load-use bubbles inserted.

Function
REQ-019 Load-use hazard (lu) = ex_valid_out & ex_Ctl_MemRead_out & ex_Rd_out!=0 & id_valid_in & ((id_use_Rs1_in & id_Rs1_in==ex_Rd_out) | (id_use_Rs2_in & id_Rs2_in==ex_Rd_out)); combinational from registered EX state.
REQ-020 Per-edge priority: flush_in > hold_in > lu > normal load.
REQ-021 flush_in=1: next EX slot is a bubble regardless of hold_in/lu; stall_out=0.
REQ-022 Bubble = ex_valid_out 0, all ex_Ctl_* 0; index/data fields don't-care but zeroed.
REQ-023 hold_in=1 (no flush): all EX registers keep value; stall_out=1; counter unchanged.
REQ-024 lu=1 (no flush/hold): EX loads bubble, stall_out=1, stall_cnt_out +1 unless at all-ones.
REQ-025 Otherwise: EX loads decode fields, ex_valid_out=id_valid_in; controls zeroed when id_valid_in=0; stall_out=0.
REQ-026 Latency: decode inputs appear on ex_* exactly 1 cycle after capture edge.
REQ-027 Load-use stall lasts exactly one cycle: bubble clears lu next cycle; back-to-back dependent loads each stall once.
REQ-028 Rd=x0 loads never stall; id_use_*=0 suppresses match.
REQ-029 stall_cnt_out saturates at 2^CNT_W-1, never wraps.
REQ-030 stall_out combinational; no registered dependence on id_* except via EX state.

Reset
REQ-031 rst_n low asynchronously: ex_valid_out 0, all ex_Ctl_* 0, all ex_* index/data 0, stall_cnt_out 0.
REQ-032 stall_out 0 during reset; first capture on first rising edge after rst_n deasserts.
REQ-033 Reset mid-stall or mid-hold discards held instruction; no bubble or count carries over.

Structure
REQ-034 Shared package holds ALUOp encodings, XLEN default and a control-bundle struct/constants for Ctl fields.
REQ-035 One sub-module natural: hazard_detect (combinational lu/stall_out decision); pipeline register stays in id_ex_stage.

Verification
REQ-036 Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, stall_cnt_out=0.
REQ-037 lw x5 in EX, add x6,x5,x7 in decode -> stall_out=1 one cycle, bubble in EX, add enters EX next cycle, stall_cnt_out=1.
REQ-038 lw x0 in EX, decode reads x0 -> stall_out=0, no bubble.
REQ-039 lu active and flush_in=1 same cycle -> bubble, stall_out=0, stall_cnt_out unchanged.
REQ-040 hold_in=1 for 3 cycles with valid EX -> ex_* stable, stall_out=1, counter unchanged; resumes on release.
REQ-041 CNT_W=4, 17 load-use events -> stall_cnt_out stops at 15.
